// File: rtl/dmux_pkg.sv
// Shared helpers for the N-way stream demultiplexer.
package dmux_pkg;

  // Select width for n channels; never zero so a 1-bit select port still exists.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel FIFO with a registered head word that holds its last value when empty.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             can_take,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             pop, full, fresh_head;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid    = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = valid & ready;
  assign can_take = !full | pop;
  assign rd_nxt   = pop ? bump(rd_ptr) : rd_ptr;
  // The next head is the incoming word only when no older word survives this edge.
  assign fresh_head = push && (count == CW'(pop));

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) dout <= fresh_head ? din : mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmux_nway_stream.sv
// Routes one valid/ready stream to one of N buffered channels, or to all of them.
module dmux_nway_stream
  import dmux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  parameter  int DEPTH = 2,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               sel_err
);
  logic [N-1:0]            hit, can_take, push;
  logic [N-1:0][WIDTH-1:0] ch_data;
  logic                    sel_ok, accept;

  // One-hot decode by comparison, so an out-of-range select matches nothing.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) hit[i] = (32'(in_sel) == 32'(i));
  end

  assign sel_ok = 32'(in_sel) < 32'(N);

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast)    in_ready = &can_take;
      else if (sel_ok) in_ready = |(hit & can_take);
      else             in_ready = 1'b1;
    end
  end

  assign accept   = in_valid & in_ready;
  assign push     = !accept ? '0 : (in_bcast ? {N{1'b1}} : hit);
  assign out_data = ch_data;

  for (genvar g = 0; g < N; g++) begin : g_ch
    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[g]),
      .din      (in_data),
      .ready    (out_ready[g]),
      .can_take (can_take[g]),
      .valid    (out_valid[g]),
      .dout     (ch_data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               sel_err <= 1'b0;
    else if (accept && !in_bcast && !sel_ok)  sel_err <= 1'b1;
  end

endmodule

// File: tb/tb_dmux_nway_stream.sv
// Scoreboard bench: per-channel expected-word queues fed on acceptance, drained by a monitor.
module tb_dmux_nway_stream;
  localparam int W = 16;
  localparam int NC = 4;
  localparam int DP = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    in_data;
  logic [1:0]      in_sel;
  logic            in_bcast, in_valid, in_ready;
  logic [NC*W-1:0] out_data;
  logic [NC-1:0]   out_valid, out_ready;
  logic            sel_err;

  logic [W-1:0]    d3;
  logic [1:0]      s3;
  logic            b3, v3, r3, se3;
  logic [3*W-1:0]  od3;
  logic [2:0]      ov3, or3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [NC][$];
  logic [W-1:0] last [NC];

  always #5 clk = ~clk;

  dmux_nway_stream #(.WIDTH(W), .N(NC), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err));

  dmux_nway_stream #(.WIDTH(W), .N(3), .DEPTH(DP)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_sel(s3), .in_bcast(b3),
    .in_valid(v3), .in_ready(r3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .sel_err(se3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the monitor has already retired this edge's pops at +1.
  task automatic step(input bit v, input logic [1:0] s, input bit b, input logic [W-1:0] d,
                      input logic [NC-1:0] rdy, input bit r);
    bit er;
    @(negedge clk);
    rst_n = r; in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = rdy;
    #2;
    if (!r) er = 1'b0;
    else if (b) begin
      er = 1'b1;
      for (int i = 0; i < NC; i++) if (exp_q[i].size() >= DP) er = 1'b0;
    end else er = (exp_q[s].size() < DP);
    chk("in_ready", in_ready, er);
    if (!r) begin
      for (int i = 0; i < NC; i++) begin exp_q[i].delete(); last[i] = '0; end
    end else if (v && er) begin
      for (int i = 0; i < NC; i++) if (b || s == i[1:0]) exp_q[i].push_back(d);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1) begin
        chk("sel_err_n4", sel_err, 1'b0);
        for (int i = 0; i < NC; i++) begin
          chk($sformatf("out_valid[%0d]", i), out_valid[i], exp_q[i].size() > 0);
          chk($sformatf("out_data[%0d]", i), out_data[i*W +: W],
              (exp_q[i].size() > 0) ? exp_q[i][0] : last[i]);
          if (out_valid[i] && out_ready[i] && exp_q[i].size() > 0) last[i] = exp_q[i].pop_front();
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '1;
    d3 = '0; s3 = '0; b3 = 1'b0; v3 = 1'b0; or3 = '1;
    for (int i = 0; i < NC; i++) last[i] = '0;
    step(0, 0, 0, 0, 4'hF, 0);
    step(0, 0, 0, 0, 4'hF, 0);

    // N=3 instance: out-of-range select is swallowed and flagged.
    step(0, 0, 0, 0, 4'hF, 1);
    chk("n3_reset_valid", ov3, 3'b000);
    chk("n3_reset_data", od3, '0);
    v3 = 1'b1; s3 = 2'b11; d3 = 16'h3333; #1;
    chk("n3_badsel_ready", r3, 1'b1);
    chk("n3_sel_err_pre", se3, 1'b0);
    step(0, 0, 0, 0, 4'hF, 1);
    v3 = 1'b1; s3 = 2'd2; d3 = 16'h2222; #1;
    chk("n3_sel_err_set", se3, 1'b1);
    chk("n3_badsel_novalid", ov3, 3'b000);
    chk("n3_uni_ready", r3, 1'b1);
    step(0, 0, 0, 0, 4'hF, 1);
    v3 = 1'b0; #1;
    chk("n3_uni_valid", ov3, 3'b100);
    chk("n3_uni_data", od3[2*W +: W], 16'h2222);
    chk("n3_sel_err_hold", se3, 1'b1);

    // Unicast to channel 2.
    step(1, 2, 0, 16'hA5A5, 4'hF, 1);
    step(0, 0, 0, 0, 4'hF, 1);
    step(0, 0, 0, 0, 4'hF, 1);

    // Channel 1 stalled; channel 0 keeps flowing.
    step(1, 1, 0, 16'h0001, 4'b1101, 1);
    step(1, 1, 0, 16'h0002, 4'b1101, 1);
    step(1, 1, 0, 16'h0003, 4'b1101, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 16'h1000 + W'(k), 4'b1101, 1);
    step(1, 1, 0, 16'h0003, 4'b1111, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 4'hF, 1);

    // Broadcast blocked by a full, stalled channel 3.
    step(1, 3, 0, 16'h0031, 4'b0111, 1);
    step(1, 3, 0, 16'h0032, 4'b0111, 1);
    step(1, 0, 1, 16'hBEEF, 4'b0111, 1);
    step(1, 0, 1, 16'hBEEF, 4'b0111, 1);
    step(0, 0, 0, 0, 4'hF, 1);
    step(0, 0, 0, 0, 4'hF, 1);
    step(1, 0, 1, 16'hBEEF, 4'hF, 1);
    step(0, 0, 0, 0, 4'hF, 1);
    step(0, 0, 0, 0, 4'hF, 1);

    // Push into full channel 0 while it pops.
    step(1, 0, 0, 16'h00A1, 4'b1110, 1);
    step(1, 0, 0, 16'h00A2, 4'b1110, 1);
    step(1, 0, 0, 16'h0C0C, 4'b1111, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 4'hF, 1);

    // Reset with words buffered in channels 1 and 2.
    step(1, 1, 0, 16'h1111, 4'h0, 1);
    step(1, 2, 0, 16'h2222, 4'h0, 1);
    chk("n3_sel_err_before_rst", se3, 1'b1);
    step(0, 0, 0, 0, 4'h0, 0);
    step(0, 0, 0, 0, 4'hF, 1);
    chk("n3_sel_err_after_rst", se3, 1'b0);
    step(0, 0, 0, 0, 4'hF, 1);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      logic [NC-1:0] rdy;
      for (int i = 0; i < NC; i++) rdy[i] = ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
           W'($urandom), rdy, $urandom_range(0, 199) != 0);
    end
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 4'hF, 1);
    for (int i = 0; i < NC; i++) chk($sformatf("drained[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
